sar_avg_filter: RTL
===================

Name: sar_avg_filter

Overview:
- Sits directly downstream of the 8-bit SAR conversion controller.
- Consumes each finished conversion: the 8-bit code, qualified by the one-cycle done pulse.
- Accumulates a window of 2^LOG2_N codes and emits the rounded mean, plus the window min and max.
- Output uses a valid/ready handshake with a sticky overrun flag for when the consumer stalls.

Parameters:
- DATA_W, 8: width of SAR code and averaged result.
- LOG2_N, 2: log2 of window length. Legal range 0..4; 0 means pass-through.

Ports:
- clk, input, 1: sole clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- sample_valid, input, 1: one-cycle pulse per completed conversion (SAR done).
- sample_data, input, DATA_W: SAR result; sampled only when sample_valid=1.
- avg_valid, output, 1: result registers hold an unconsumed window result.
- avg_ready, input, 1: consumer accepts the result when avg_valid and avg_ready are both 1 at a clock edge.
- avg_data, output, DATA_W: rounded window mean.
- avg_min, output, DATA_W: smallest code in the window.
- avg_max, output, DATA_W: largest code in the window.
- overrun, output, 1: sticky; a completed window was dropped because the output was still occupied.
- win_count, output, LOG2_N+1: samples accumulated in the current window, 0..2^LOG2_N-1.

Behaviour:
- Reset (rst=1 at edge) clears everything: accumulator, win_count, running min/max, avg_valid, avg_data, avg_min, avg_max and overrun all go to 0.
- Reset mid-window discards the partial window.
- Accumulator:
  - Width is DATA_W+LOG2_N; no overflow is possible.
  - Running min initialises from the first sample of each window, as does running max.
- On each sample_valid edge:
  - sum += sample_data; min/max updated; win_count increments.
  - When this sample is the 2^LOG2_N-th: window completes, accumulator/count/min/max are cleared, and the next sample starts a fresh window in the very next cycle.
- Completed result:
  - mean = (sum + 2^(LOG2_N-1)) >> LOG2_N, i.e. round-half-up; for LOG2_N=0 the mean is the sample.
  - The full sum includes the completing sample.
  - Result always fits in DATA_W bits, since max = 255*N + N/2 < 256*N.
- Latency: a window completing at edge t gives avg_valid=1 with avg_data/min/max valid after edge t (one register stage).
- Output state machine, two states:
  - EMPTY (avg_valid=0): a completed window loads the output registers -> FULL.
  - FULL (avg_valid=1): outputs held stable.
    - Handshake with no simultaneous completion -> EMPTY.
    - Handshake with a simultaneous completion -> new result loaded, stays FULL (no bubble).
    - Completion without handshake -> new result discarded, old result kept, overrun set to 1.
- overrun clears only on rst.
- avg_ready while EMPTY has no effect.
- sample_valid held high for several cycles counts one sample per cycle; upstream guarantees pulses.
- sample_data changing while sample_valid=0 has no effect.

Test Plan:
- LOG2_N=2, samples 10,20,30,41, avg_ready=1 -> one cycle after the 4th sample: avg_valid=1, avg_data=25 (103>>2), avg_min=10, avg_max=41, then avg_valid=0; win_count sequence 1,2,3,0.
- LOG2_N=2, four samples of 255 -> avg_data=255, min=max=255; four samples of 0 -> avg_data=0; samples 1,1,1,2 (sum 5+2=7) -> avg_data=1; samples 1,2,2,2 (sum 7+2=9) -> avg_data=2.
- Backpressure:
  - avg_ready=0 throughout, windows [4,4,4,4] then [8,8,8,8] -> avg_data stays 4 and overrun=1 after the 8th sample.
  - Raising avg_ready drops avg_valid; overrun stays 1 until rst.
- Simultaneous events: hold avg_ready=0 after window [4,4,4,4]; on the cycle window [100,100,100,100] completes, pulse avg_ready -> avg_valid stays 1, avg_data=100, overrun=0.
- Reset mid-window: samples 50,60, rst for one cycle, then 1,2,3,4 -> avg_data=3 (10+2=12>>2), min=1, max=4; win_count=0 immediately after rst.
- LOG2_N=0, random codes with the SAR-controller-style done pulses, avg_ready=1 -> avg_data equals each code one cycle later; min=max=code.

Source files
------------

// File: rtl/sar_avg_filter.sv
// sar_avg_filter
//   Windowed averaging filter for the 8-bit SAR conversion controller.
//   Each completed conversion (sample_valid pulse) is accumulated; after
//   2^LOG2_N samples the rounded mean plus the window min/max are presented
//   on a valid/ready output port. A completed window that cannot be stored
//   because the output still holds an unconsumed result is dropped and the
//   sticky overrun flag is raised.
//
// Ports
//   clk          : clock, all logic on the rising edge
//   rst          : synchronous active-high reset
//   sample_valid : one-cycle pulse per finished conversion
//   sample_data  : conversion code, sampled only while sample_valid=1
//   avg_valid    : output registers hold an unconsumed result (FSM state bit)
//   avg_ready    : consumer accepts the result when avg_valid & avg_ready
//   avg_data     : rounded (half-up) window mean
//   avg_min      : smallest code of the window
//   avg_max      : largest code of the window
//   overrun      : sticky, a completed window was dropped; cleared by rst only
//   win_count    : samples accumulated in the current window
//
// Handshake: a result is transferred on every rising edge where avg_valid=1
// and avg_ready=1. While avg_valid=1 the result registers do not change
// except when that same edge transfers the old result and a new window
// completes, in which case the new result replaces it with no bubble.
module sar_avg_filter #(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   sample_data,
  output logic                avg_valid,
  input  logic                avg_ready,
  output logic [DATA_W-1:0]   avg_data,
  output logic [DATA_W-1:0]   avg_min,
  output logic [DATA_W-1:0]   avg_max,
  output logic                overrun,
  output logic [LOG2_N:0]     win_count
);

  localparam int N     = 1 << LOG2_N;
  localparam int SUM_W = DATA_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  // Half an LSB of the shifted result; 0 when LOG2_N=0 (pass-through).
  localparam int ROUND = (1 << LOG2_N) >> 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------
  // Window accumulation
  // ---------------------------------------------------------------------
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;

  logic [SUM_W-1:0]  sum_full;
  logic [SUM_W-1:0]  rounded;
  logic [DATA_W-1:0] win_min;
  logic [DATA_W-1:0] win_max;
  logic [DATA_W-1:0] mean;
  logic              first_smp;
  logic              last_smp;
  logic              complete;

  always_comb begin
    first_smp = (cnt_q == '0);
    last_smp  = (cnt_q == CNT_W'(N - 1));
    complete  = sample_valid && last_smp;

    // Sum including the sample arriving this cycle, so the completing
    // sample is part of the mean.
    sum_full  = acc_q + SUM_W'(sample_data);
    rounded   = sum_full + SUM_W'(ROUND);
    // Cannot overflow DATA_W: the largest rounded sum is 255*N + N/2 < 256*N.
    mean      = DATA_W'(rounded >> LOG2_N);

    // First sample of a window seeds min/max regardless of stale contents.
    win_min   = (first_smp || (sample_data < min_q)) ? sample_data : min_q;
    win_max   = (first_smp || (sample_data > max_q)) ? sample_data : max_q;

    acc_d = acc_q;
    cnt_d = cnt_q;
    min_d = min_q;
    max_d = max_q;
    if (sample_valid) begin
      if (last_smp) begin
        // Window done: clear so the next cycle starts a fresh window.
        acc_d = '0;
        cnt_d = '0;
        min_d = '0;
        max_d = '0;
      end else begin
        acc_d = sum_full;
        cnt_d = cnt_q + CNT_W'(1);
        min_d = win_min;
        max_d = win_max;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      min_q <= '0;
      max_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  // ---------------------------------------------------------------------
  // Output FSM: EMPTY / FULL
  // ---------------------------------------------------------------------
  state_e state_q, state_d;
  logic   handshake;
  logic   load;
  logic   set_overrun;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (complete) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (avg_ready && !complete) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    handshake   = (state_q == ST_FULL) && avg_ready;
    // Load when the slot is free or is being freed on this very edge.
    load        = complete && ((state_q == ST_EMPTY) || handshake);
    set_overrun = complete && (state_q == ST_FULL) && !avg_ready;
  end

  logic [DATA_W-1:0] avg_data_q;
  logic [DATA_W-1:0] avg_min_q;
  logic [DATA_W-1:0] avg_max_q;
  logic              overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      avg_data_q <= '0;
      avg_min_q  <= '0;
      avg_max_q  <= '0;
    end else if (load) begin
      avg_data_q <= mean;
      avg_min_q  <= win_min;
      avg_max_q  <= win_max;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (set_overrun) begin
      overrun_q <= 1'b1;
    end
  end

  assign avg_valid = (state_q == ST_FULL);
  assign avg_data  = avg_data_q;
  assign avg_min   = avg_min_q;
  assign avg_max   = avg_max_q;
  assign overrun   = overrun_q;
  assign win_count = cnt_q;

endmodule
